slt_seq_unit: RTL and testbench

Multi-cycle, parametrised set-less-than unit that succeeds the combinational 16-bit slt in the ALU datapath. It computes A-B with a CHUNK-bit ripple subtractor over WIDTH/CHUNK cycles and supports signed (SLT) and unsigned (SLTU) modes. Operands enter and results leave through valid/ready handshakes, so the unit can be stalled by the ALU result mux.

---
 rtl/slt_seq_unit_pkg.sv | 29 ++
 rtl/slt_seq_unit_if.sv | 42 ++++
 rtl/slt_seq_unit_chunk_sub.sv | 33 +++
 rtl/slt_seq_unit.sv | 136 +++++++++++++
 tb/tb_slt_seq_unit.sv | 242 ++++++++++++++++++++++++
 5 files changed

// File: rtl/slt_seq_unit_pkg.sv
// +--------------------------------------------------------------------------+
// | slt_pkg: shared types, mode encodings and sizing helpers for slt_seq_unit |
// | Revision: 1.0                                                             |
// +--------------------------------------------------------------------------+
`default_nettype none

package slt_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic MODE_SIGNED   = 1'b0;
  localparam logic MODE_UNSIGNED = 1'b1;

  function automatic int calc_nchunk(input int width, input int chunk);
    return width / chunk;
  endfunction

  // A single-chunk configuration still needs a 1-bit counter register.
  function automatic int calc_cnt_w(input int nchunk);
    return (nchunk > 1) ? $clog2(nchunk) : 1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/slt_seq_unit_if.sv
// +--------------------------------------------------------------------------+
// | slt_seq_unit_if: operand/result handshake bundle (eq with SLT_EQ_OUT_EN)  |
// | Revision: 1.0                                                             |
// +--------------------------------------------------------------------------+
`default_nettype none

interface slt_seq_unit_if #(
  parameter int WIDTH = 16
);

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             mode;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out;
  logic             overflow;
`ifdef SLT_EQ_OUT_EN
  logic             eq;
`endif

  modport master (
    output in_valid, a, b, mode, out_ready,
`ifdef SLT_EQ_OUT_EN
    input  eq,
`endif
    input  in_ready, out_valid, out, overflow
  );

  modport slave (
    input  in_valid, a, b, mode, out_ready,
`ifdef SLT_EQ_OUT_EN
    output eq,
`endif
    output in_ready, out_valid, out, overflow
  );

endinterface

`default_nettype wire

// File: rtl/slt_seq_unit_chunk_sub.sv
// +--------------------------------------------------------------------------+
// | slt_chunk_sub: CHUNK-bit ripple adder used as one slice of A + ~B + 1     |
// | Revision: 1.0                                                             |
// +--------------------------------------------------------------------------+
`default_nettype none

module slt_chunk_sub
  import slt_pkg::*;
#(
  parameter int CHUNK = 4
) (
  input  wire logic [CHUNK-1:0] a_chunk,
  input  wire logic [CHUNK-1:0] b_n_chunk,
  input  wire logic             cin,
  output logic      [CHUNK-1:0] sum,
  output logic                  cout
);

  logic [CHUNK:0] w_carry;

  assign w_carry[0] = cin;

  for (genvar i = 0; i < CHUNK; i++) begin : g_bit
    assign sum[i]       = a_chunk[i] ^ b_n_chunk[i] ^ w_carry[i];
    assign w_carry[i+1] = (a_chunk[i] & b_n_chunk[i]) |
                          (w_carry[i] & (a_chunk[i] ^ b_n_chunk[i]));
  end

  assign cout = w_carry[CHUNK];

endmodule

`default_nettype wire

// File: rtl/slt_seq_unit.sv
// +--------------------------------------------------------------------------+
// | slt_seq_unit: multi-cycle SLT/SLTU, one CHUNK-bit slice of A-B per cycle  |
// | Optional A==B flag on eq when SLT_EQ_OUT_EN is defined. Revision: 1.0     |
// +--------------------------------------------------------------------------+
`default_nettype none

module slt_seq_unit
  import slt_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input wire logic    clk,
  input wire logic    rst,
  slt_seq_unit_if.slave bus
);

  localparam int NCHUNK = calc_nchunk(WIDTH, CHUNK);
  localparam int CNT_W  = calc_cnt_w(NCHUNK);
  localparam logic [CNT_W-1:0] C_LAST = CNT_W'(NCHUNK - 1);

  if ((CHUNK < 1) || (CHUNK > WIDTH) || ((WIDTH % CHUNK) != 0)) begin : g_bad_cfg
    $error("slt_seq_unit: WIDTH must be a positive multiple of CHUNK");
  end

  state_t r_state;
  state_t w_next_state;

  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic             r_mode;
  logic [CNT_W-1:0] r_cnt;
  logic             r_carry;
  logic [WIDTH-1:0] r_diff;

  logic             w_accept;
  int               w_base;
  logic [CHUNK-1:0] w_a_chunk;
  logic [CHUNK-1:0] w_b_n_chunk;
  logic [CHUNK-1:0] w_sum;
  logic             w_cout;
  logic             w_ovf;
  logic             w_lt;

  assign w_accept    = (r_state == IDLE) && bus.in_valid;
  assign w_base      = int'(r_cnt) * CHUNK;
  assign w_a_chunk   = r_a[w_base +: CHUNK];
  assign w_b_n_chunk = ~r_b[w_base +: CHUNK];

  slt_chunk_sub #(
    .CHUNK (CHUNK)
  ) u_chunk_sub (
    .a_chunk   (w_a_chunk),
    .b_n_chunk (w_b_n_chunk),
    .cin       (r_carry),
    .sum       (w_sum),
    .cout      (w_cout)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Operands are latched once; the subtractor then walks r_diff LSB chunk first.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_a     <= '0;
      r_b     <= '0;
      r_mode  <= MODE_SIGNED;
      r_cnt   <= '0;
      r_carry <= 1'b0;
      r_diff  <= '0;
    end else if (w_accept) begin
      r_a     <= bus.a;
      r_b     <= bus.b;
      r_mode  <= bus.mode;
      r_cnt   <= '0;
      r_carry <= 1'b1;
    end else if (r_state == RUN) begin
      r_diff[w_base +: CHUNK] <= w_sum;
      r_carry                 <= w_cout;
      r_cnt                   <= (r_cnt == C_LAST) ? '0 : r_cnt + 1'b1;
    end
  end

  // Signed overflow needs differing operand signs and a result sign unlike A.
  assign w_ovf = (r_mode == MODE_SIGNED) &&
                 (r_a[WIDTH-1] != r_b[WIDTH-1]) &&
                 (r_diff[WIDTH-1] != r_a[WIDTH-1]);
  assign w_lt  = (r_mode == MODE_SIGNED) ? (r_diff[WIDTH-1] ^ w_ovf) : ~r_carry;

  always_comb begin
    w_next_state  = r_state;
    bus.in_ready  = 1'b0;
    bus.out_valid = 1'b0;
    bus.out       = '0;
    bus.overflow  = 1'b0;
`ifdef SLT_EQ_OUT_EN
    bus.eq        = 1'b0;
`endif
    case (r_state)
      IDLE: begin
        bus.in_ready = 1'b1;
        if (bus.in_valid) begin
          w_next_state = RUN;
        end
      end
      RUN: begin
        if (r_cnt == C_LAST) begin
          w_next_state = DONE;
        end
      end
      DONE: begin
        bus.out_valid = 1'b1;
        bus.out       = {{(WIDTH-1){1'b0}}, w_lt};
        bus.overflow  = w_ovf;
`ifdef SLT_EQ_OUT_EN
        bus.eq        = (r_diff == '0);
`endif
        if (bus.out_ready) begin
          w_next_state = IDLE;
        end
      end
      default: begin
        w_next_state = IDLE;
      end
    endcase
  end

endmodule

`default_nettype wire

// File: tb/tb_slt_seq_unit.sv
// +--------------------------------------------------------------------------+
// | tb_slt_seq_unit: randomized scoreboard bench for slt_seq_unit             |
// | Revision: 1.0                                                             |
// +--------------------------------------------------------------------------+
`default_nettype none

module tb_slt_seq_unit;
  import slt_pkg::*;

  localparam int WIDTH  = 16;
  localparam int CHUNK  = 4;
  localparam int NCHUNK = WIDTH / CHUNK;

  logic clk = 1'b0;
  logic rst = 1'b1;

  always #5 clk = ~clk;

  slt_seq_unit_if #(.WIDTH(WIDTH)) bus ();

  slt_seq_unit #(
    .WIDTH (WIDTH),
    .CHUNK (CHUNK)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic [WIDTH-1:0] out;
    logic             ovf;
    logic             eq;
    int               acc;
  } exp_t;

  exp_t exp_q[$];
  int   total      = 0;
  int   bad        = 0;
  int   cycle_cnt  = 0;
  bit   busy       = 1'b0;
  bit   mon_en     = 1'b0;
  bit   rand_ready = 1'b0;
  int   stall_cnt  = 0;

  always @(posedge clk) cycle_cnt <= cycle_cnt + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Reference: compare as mathematical integers, overflow = true difference out of range.
  function automatic exp_t model(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                 input logic m);
    exp_t   e;
    longint sa, sb, ua, ub, d, max_s, min_s;
    sa    = longint'($signed(a));
    sb    = longint'($signed(b));
    ua    = longint'({48'd0, a});
    ub    = longint'({48'd0, b});
    d     = sa - sb;
    max_s = (longint'(1) <<< (WIDTH - 1)) - 1;
    min_s = -(longint'(1) <<< (WIDTH - 1));
    e.out = '0;
    if (m == MODE_UNSIGNED) begin
      e.out[0] = (ua < ub);
      e.ovf    = 1'b0;
    end else begin
      e.out[0] = (sa < sb);
      e.ovf    = (d > max_s) || (d < min_s);
    end
    e.eq  = (a == b);
    e.acc = 0;
    return e;
  endfunction

  task automatic do_op(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input logic m);
    int   n;
    exp_t e;
    n = 0;
    @(posedge clk); #1;
    bus.in_valid = 1'b1;
    bus.a        = a;
    bus.b        = b;
    bus.mode     = m;
    do begin
      @(negedge clk);
      n++;
    end while (!bus.in_ready && n < 200);
    if (!bus.in_ready) begin
      total++;
      bad++;
      $display("FAIL accept_timeout: in_ready got 0 expected 1 within 200 cycles");
      bus.in_valid = 1'b0;
      return;
    end
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    bus.a        = WIDTH'($urandom);
    bus.b        = WIDTH'($urandom);
    e            = model(a, b, m);
    e.acc        = cycle_cnt;
    exp_q.push_back(e);
    busy         = 1'b1;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((busy || exp_q.size() != 0) && n < 500) begin
      @(posedge clk);
      n++;
    end
    if (busy || exp_q.size() != 0) begin
      total++;
      bad++;
      $display("FAIL drain_timeout: pending got %0d expected 0", exp_q.size());
    end
  endtask

  // Consumer: forced stall window around a chosen result, otherwise always/random ready.
  initial begin
    bus.out_ready = 1'b1;
    forever begin
      @(posedge clk); #1;
      if (stall_cnt > 0) begin
        bus.out_ready = 1'b0;
        if (bus.out_valid) stall_cnt--;
      end else begin
        bus.out_ready = rand_ready ? ($urandom_range(0, 3) != 0) : 1'b1;
      end
    end
  end

  // Monitor: pops the scoreboard on each result handshake.
  initial begin
    bit prev_v;
    bit hs;
    prev_v = 1'b0;
    wait (mon_en);
    forever begin
      @(negedge clk);
      hs = 1'b0;
      if (!rst) begin
        check("in_ready", 32'(bus.in_ready), 32'(!busy));
`ifdef SLT_EQ_OUT_EN
        if (!bus.out_valid) check("eq_idle", 32'(bus.eq), 32'd0);
`endif
        if (bus.out_valid) begin
          if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_result: out_valid got 1 expected 0");
          end else begin
            if (!prev_v) check("latency", 32'(cycle_cnt - exp_q[0].acc), 32'(NCHUNK));
            check("out", 32'(bus.out), 32'(exp_q[0].out));
            check("overflow", 32'(bus.overflow), 32'(exp_q[0].ovf));
`ifdef SLT_EQ_OUT_EN
            check("eq", 32'(bus.eq), 32'(exp_q[0].eq));
`endif
            hs = bus.out_ready;
          end
        end
        prev_v = bus.out_valid;
      end else begin
        prev_v = 1'b0;
      end
      if (hs) begin
        void'(exp_q.pop_front());
        @(posedge clk); #1;
        busy   = 1'b0;
        prev_v = 1'b0;
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: time got %0t expected completion", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [WIDTH-1:0] ra, rb;
    bus.in_valid = 1'b0;
    bus.a        = '0;
    bus.b        = '0;
    bus.mode     = MODE_SIGNED;
    rst          = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_in_ready", 32'(bus.in_ready), 32'd1);
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_out", 32'(bus.out), 32'd0);
    check("rst_overflow", 32'(bus.overflow), 32'd0);
    mon_en = 1'b1;

    do_op(16'd4, 16'd2, MODE_SIGNED);
    do_op(16'd2, 16'd4, MODE_SIGNED);
    do_op(16'hFFFC, 16'hFFFE, MODE_SIGNED);
    do_op(16'hFFFE, 16'hFFFC, MODE_SIGNED);
    do_op(16'h8000, 16'h0001, MODE_SIGNED);
    do_op(16'h8000, 16'h0001, MODE_UNSIGNED);
    do_op(16'h7FFF, 16'h8000, MODE_SIGNED);
    do_op(16'h0000, 16'hFFFF, MODE_UNSIGNED);
    drain();

    stall_cnt = 5;
    do_op(16'h7FFF, 16'h7FFF, MODE_SIGNED);
    drain();

    // Abort in the second RUN cycle; the op must never be presented.
    do_op(16'd4, 16'd2, MODE_SIGNED);
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    exp_q.delete();
    busy = 1'b0;
    repeat (NCHUNK + 3) @(posedge clk);
    do_op(16'd2, 16'd4, MODE_SIGNED);
    drain();

    rand_ready = 1'b1;
    for (int i = 0; i < 60; i++) begin
      ra = WIDTH'($urandom);
      rb = ($urandom_range(0, 3) == 0) ? ra : WIDTH'($urandom);
      if ($urandom_range(0, 5) == 0) ra[WIDTH-1] = ~rb[WIDTH-1];
      do_op(ra, rb, logic'($urandom_range(0, 1)));
    end
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
